// File: rtl/v_elem_sequencer_if.sv
// Handshake/bus bundle between the element sequencer, the vector regfile and the element ALU.
// The master modport is the sequencer side; the slave modport is the regfile/ALU/control side.
interface v_elem_sequencer_if;
  logic         start, abort;
  logic [4:0]   vs1, vs2, vd;
  logic [6:0]   vl;
  logic [2:0]   sew, lmul;
  logic [4:0]   el_rd_addr_1, el_rd_addr_2, el_addr_1, el_addr_2;
  logic [31:0]  el_data_in_1, el_data_in_2;
  logic         el_wr_en;
  logic [4:0]   el_reg_wr_addr, el_wr_addr;
  logic [127:0] el_wr_data;
  logic         op_valid, op_ready;
  logic [31:0]  op_a, op_b;
  logic         res_valid;
  logic [31:0]  res_data;
  logic         busy, done;

  modport master (
    input  start, abort, vs1, vs2, vd, vl, sew, lmul,
    input  el_data_in_1, el_data_in_2, op_ready, res_valid, res_data,
    output el_rd_addr_1, el_rd_addr_2, el_addr_1, el_addr_2,
    output el_wr_en, el_reg_wr_addr, el_wr_addr, el_wr_data,
    output op_valid, op_a, op_b, busy, done
  );

  modport slave (
    output start, abort, vs1, vs2, vd, vl, sew, lmul,
    output el_data_in_1, el_data_in_2, op_ready, res_valid, res_data,
    input  el_rd_addr_1, el_rd_addr_2, el_addr_1, el_addr_2,
    input  el_wr_en, el_reg_wr_addr, el_wr_addr, el_wr_data,
    input  op_valid, op_a, op_b, busy, done
  );
endinterface

// File: rtl/v_elem_sequencer.sv
// Walks the elements of a vector register group one at a time: read both sources,
// hand them to the element ALU, and write the result back into the destination group.
module v_elem_sequencer (
  input logic            clk,
  input logic            nrst,
  v_elem_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;

  // lmul only shapes the effective count, so it is folded into cnt at start
  typedef struct packed {
    logic [4:0] vs1, vs2, vd;
    logic [2:0] sew;
    logic [6:0] cnt;
  } cfg_t;

  state_t      state, state_nxt;
  cfg_t        cfg;
  logic [5:0]  idx;
  logic [31:0] res_q;

  function automatic logic [2:0] epr_log2(input logic [2:0] s);
    case (s)
      3'b001:  return 3'd3;
      3'b010:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [2:0] rpg_log2(input logic [2:0] l);
    case (l)
      3'b001:  return 3'd1;
      3'b010:  return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] sew_mask(input logic [2:0] s);
    case (s)
      3'b001:  return 32'h0000_ffff;
      3'b010:  return 32'hffff_ffff;
      default: return 32'h0000_00ff;
    endcase
  endfunction

  logic [6:0]  cap, cnt_in;
  logic [2:0]  esh;
  logic [4:0]  off, lane;
  logic [7:0]  shamt;
  logic [31:0] mask;
  logic        last;

  assign cap    = 7'd1 << (epr_log2(bus.sew) + rpg_log2(bus.lmul));
  assign cnt_in = (bus.vl < cap) ? bus.vl : cap;
  assign esh    = epr_log2(cfg.sew);
  assign off    = 5'(idx >> esh);
  assign lane   = 5'(idx & 6'((6'd1 << esh) - 6'd1));
  // lane * element width, where width = 8 << (4 - log2(epr))
  assign shamt  = {lane, 3'b000} << (3'd4 - esh);
  assign mask   = sew_mask(cfg.sew);
  assign last   = ({1'b0, idx} == cfg.cnt - 7'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = (cnt_in == 7'd0) ? DONE : ISSUE;
      ISSUE:   if (bus.op_ready) state_nxt = WAIT;
      WAIT:    if (bus.res_valid) state_nxt = WRITE;
      WRITE:   state_nxt = last ? DONE : ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.abort && state != IDLE) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      cfg   <= '0;
      idx   <= '0;
      res_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.start) begin
        cfg <= '{vs1: bus.vs1, vs2: bus.vs2, vd: bus.vd, sew: bus.sew, cnt: cnt_in};
        idx <= '0;
      end
      if (state == WAIT && bus.res_valid) res_q <= bus.res_data & mask;
      if (state == WRITE && state_nxt == ISSUE) idx <= idx + 6'd1;
    end
  end

  assign bus.busy           = (state != IDLE);
  assign bus.done           = (state == DONE);
  assign bus.op_valid       = (state == ISSUE);
  assign bus.op_a           = bus.op_valid ? (bus.el_data_in_1 & mask) : 32'd0;
  assign bus.op_b           = bus.op_valid ? (bus.el_data_in_2 & mask) : 32'd0;
  assign bus.el_rd_addr_1   = cfg.vs1 + off;
  assign bus.el_rd_addr_2   = cfg.vs2 + off;
  assign bus.el_addr_1      = lane;
  assign bus.el_addr_2      = lane;
  assign bus.el_wr_en       = (state == WRITE);
  assign bus.el_reg_wr_addr = cfg.vd + off;
  assign bus.el_wr_addr     = lane;
  assign bus.el_wr_data     = bus.el_wr_en ? ({96'd0, res_q} << shamt) : 128'd0;
endmodule

// File: tb/tb_v_elem_sequencer.sv
// Directed bench: regfile and 1-cycle adder ALU models around v_elem_sequencer,
// with per-scenario tasks checking hand-computed write streams and control timing.
module tb_v_elem_sequencer;
  logic clk = 1'b0;
  logic nrst;
  v_elem_sequencer_if bus();

  v_elem_sequencer dut (.clk(clk), .nrst(nrst), .bus(bus));

  always #5 clk = ~clk;

  logic [127:0] rf [32];
  int           cur_ew = 8;
  assign bus.el_data_in_1 = 32'(rf[bus.el_rd_addr_1] >> (bus.el_addr_1 * cur_ew));
  assign bus.el_data_in_2 = 32'(rf[bus.el_rd_addr_2] >> (bus.el_addr_2 * cur_ew));

  int vec = 0;
  int errs = 0;

  // ALU model and write/busy/done monitor, all on the falling edge
  logic         alu_en = 1'b1;
  logic         pend = 1'b0;
  logic [31:0]  sum = '0;
  int           n_wr = 0, n_busy = 0, n_done = 0, done_pos = 0;
  logic [4:0]   wr_reg  [256];
  logic [4:0]   wr_lane [256];
  logic [127:0] wr_dat  [256];

  always @(negedge clk) begin
    if (bus.el_wr_en && n_wr < 256) begin
      wr_reg[n_wr]  = bus.el_reg_wr_addr;
      wr_lane[n_wr] = bus.el_wr_addr;
      wr_dat[n_wr]  = bus.el_wr_data;
      n_wr++;
    end
    if (bus.done) begin
      done_pos = n_busy;
      n_done++;
    end
    if (bus.busy) n_busy++;
    bus.res_valid = pend;
    bus.res_data  = sum;
    pend = alu_en && bus.op_valid && bus.op_ready;
    sum  = bus.op_a + bus.op_b;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                        input logic [6:0] l, input logic [2:0] sw, input logic [2:0] lm);
    bus.vs1 = s1; bus.vs2 = s2; bus.vd = d; bus.vl = l; bus.sew = sw; bus.lmul = lm;
    cur_ew = (sw == 3'b001) ? 16 : (sw == 3'b010) ? 32 : 8;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int c = 0; c < budget && bus.busy; c++) tick();
    vec++;
    if (bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL %s_timeout: busy still %b after %0d cycles, want 0", name, bus.busy, budget);
    end
  endtask

  task automatic load_basic();
    rf[2] = {32'd4, 32'd3, 32'd2, 32'd1};
    rf[3] = {32'd40, 32'd30, 32'd20, 32'd10};
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    bus.start = 1'b1; bus.abort = 1'b0; bus.op_ready = 1'b1;
    bus.vs1 = 5'd7; bus.vs2 = 5'd9; bus.vd = 5'd11; bus.vl = 7'd8; bus.sew = 3'b010; bus.lmul = 3'b001;
    repeat (2) tick();
    vec++;
    if ({bus.busy, bus.done, bus.op_valid, bus.el_wr_en} !== 4'b0000) begin
      errs++;
      $display("FAIL reset_ctrl: busy/done/op_valid/wr_en = %b, want 0000",
               {bus.busy, bus.done, bus.op_valid, bus.el_wr_en});
    end
    vec++;
    if ({bus.el_rd_addr_1, bus.el_rd_addr_2, bus.el_addr_1, bus.el_addr_2,
         bus.el_reg_wr_addr, bus.el_wr_addr} !== 30'd0) begin
      errs++;
      $display("FAIL reset_addr: rd1 %0d rd2 %0d a1 %0d a2 %0d wreg %0d wlane %0d, want all 0",
               bus.el_rd_addr_1, bus.el_rd_addr_2, bus.el_addr_1, bus.el_addr_2,
               bus.el_reg_wr_addr, bus.el_wr_addr);
    end
    vec++;
    if ({bus.el_wr_data, bus.op_a, bus.op_b} !== 192'd0) begin
      errs++;
      $display("FAIL reset_data: wr_data %h op_a %h op_b %h, want 0", bus.el_wr_data, bus.op_a, bus.op_b);
    end
    bus.start = 1'b0;
    nrst = 1'b1;
    repeat (2) tick();
    vec++;
    if (bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_release_idle: busy %b, want 0", bus.busy);
    end
  endtask

  task automatic test_basic();
    logic [127:0] exp_d [4];
    int w0, b0, d0;
    exp_d[0] = 128'h0000000b;
    exp_d[1] = 128'h00000016_00000000;
    exp_d[2] = 128'h00000021_00000000_00000000;
    exp_d[3] = 128'h0000002c_00000000_00000000_00000000;
    load_basic();
    w0 = n_wr; b0 = n_busy; d0 = n_done;
    launch(5'd2, 5'd3, 5'd5, 7'd4, 3'b010, 3'b000);
    wait_idle("basic", 40);
    vec++;
    if (n_wr - w0 !== 4) begin
      errs++;
      $display("FAIL basic_wr_count: %0d writes, want 4", n_wr - w0);
    end
    for (int i = 0; i < 4; i++) begin
      vec++;
      if (wr_reg[w0+i] !== 5'd5 || wr_lane[w0+i] !== 5'(i) || wr_dat[w0+i] !== exp_d[i]) begin
        errs++;
        $display("FAIL basic_wr[%0d]: reg %0d lane %0d data %h, want reg 5 lane %0d data %h",
                 i, wr_reg[w0+i], wr_lane[w0+i], wr_dat[w0+i], i, exp_d[i]);
      end
    end
    vec++;
    if (n_done - d0 !== 1 || done_pos - b0 !== 12) begin
      errs++;
      $display("FAIL basic_done: %0d pulses after %0d busy cycles, want 1 after 12", n_done - d0, done_pos - b0);
    end
    vec++;
    if (n_busy - b0 !== 13) begin
      errs++;
      $display("FAIL basic_busy_len: %0d cycles, want 13", n_busy - b0);
    end
  endtask

  task automatic test_group();
    int w0;
    logic [4:0] er;
    logic [127:0] ed;
    for (int k = 0; k < 16; k++) begin
      rf[8][8*k +: 8]  = 8'(k);
      rf[9][8*k +: 8]  = 8'(16 + k);
      rf[10][8*k +: 8] = 8'h10;
      rf[11][8*k +: 8] = 8'hf0;
    end
    w0 = n_wr;
    launch(5'd8, 5'd10, 5'd30, 7'd20, 3'b000, 3'b001);
    wait_idle("group", 120);
    vec++;
    if (n_wr - w0 !== 20) begin
      errs++;
      $display("FAIL group_wr_count: %0d writes, want 20", n_wr - w0);
    end
    // elements 16..19 sum to 0x100..0x103, which must truncate to 8 bits
    for (int i = 0; i < 20; i++) begin
      er = (i < 16) ? 5'd30 : 5'd31;
      ed = (i < 16) ? (128'(i + 16) << (8 * i)) : (128'(i - 16) << (8 * (i - 16)));
      vec++;
      if (wr_reg[w0+i] !== er || wr_lane[w0+i] !== 5'(i % 16) || wr_dat[w0+i] !== ed) begin
        errs++;
        $display("FAIL group_wr[%0d]: reg %0d lane %0d data %h, want reg %0d lane %0d data %h",
                 i, wr_reg[w0+i], wr_lane[w0+i], wr_dat[w0+i], er, i % 16, ed);
      end
    end
  endtask

  task automatic test_large();
    int w0, d0;
    for (int r = 12; r < 20; r++) rf[r] = '0;
    rf[15][127:112] = 16'h1234;
    rf[19][127:112] = 16'h0001;
    rf[12][15:0] = 16'hffff;
    rf[16][15:0] = 16'h0003;
    w0 = n_wr; d0 = n_done;
    launch(5'd12, 5'd16, 5'd20, 7'd40, 3'b001, 3'b010);
    wait_idle("large", 200);
    vec++;
    if (n_wr - w0 !== 32 || n_done - d0 !== 1) begin
      errs++;
      $display("FAIL large_count: %0d writes %0d done, want 32 writes 1 done", n_wr - w0, n_done - d0);
    end
    vec++;
    if (wr_reg[w0] !== 5'd20 || wr_lane[w0] !== 5'd0 || wr_dat[w0] !== 128'h2) begin
      errs++;
      $display("FAIL large_first: reg %0d lane %0d data %h, want reg 20 lane 0 data 2",
               wr_reg[w0], wr_lane[w0], wr_dat[w0]);
    end
    vec++;
    if (wr_reg[w0+31] !== 5'd23 || wr_lane[w0+31] !== 5'd7 ||
        wr_dat[w0+31] !== {16'h1235, 112'd0}) begin
      errs++;
      $display("FAIL large_last: reg %0d lane %0d data %h, want reg 23 lane 7 data 1235<<112",
               wr_reg[w0+31], wr_lane[w0+31], wr_dat[w0+31]);
    end
  endtask

  task automatic test_wrap();
    int w0;
    for (int r = 4; r < 8; r++) rf[r] = '0;
    rf[4][127:96] = 32'd7;
    rf[6][127:96] = 32'd1;
    rf[5][31:0]   = 32'hffffffff;
    rf[7][31:0]   = 32'd2;
    w0 = n_wr;
    launch(5'd4, 5'd6, 5'd31, 7'd8, 3'b010, 3'b001);
    wait_idle("wrap", 60);
    vec++;
    if (n_wr - w0 !== 8) begin
      errs++;
      $display("FAIL wrap_count: %0d writes, want 8", n_wr - w0);
    end
    vec++;
    if (wr_reg[w0+3] !== 5'd31 || wr_lane[w0+3] !== 5'd3 || wr_dat[w0+3] !== {32'd8, 96'd0}) begin
      errs++;
      $display("FAIL wrap_elem3: reg %0d lane %0d data %h, want reg 31 lane 3 data 8<<96",
               wr_reg[w0+3], wr_lane[w0+3], wr_dat[w0+3]);
    end
    vec++;
    if (wr_reg[w0+4] !== 5'd0 || wr_lane[w0+4] !== 5'd0 || wr_dat[w0+4] !== 128'h1) begin
      errs++;
      $display("FAIL wrap_elem4: reg %0d lane %0d data %h, want reg 0 lane 0 data 1",
               wr_reg[w0+4], wr_lane[w0+4], wr_dat[w0+4]);
    end
  endtask

  task automatic test_zero_vl();
    int w0;
    w0 = n_wr;
    launch(5'd1, 5'd2, 5'd3, 7'd0, 3'b000, 3'b000);
    vec++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin
      errs++;
      $display("FAIL zero_vl_done: done %b busy %b one cycle after start, want 1 1", bus.done, bus.busy);
    end
    tick();
    vec++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || n_wr !== w0) begin
      errs++;
      $display("FAIL zero_vl_end: done %b busy %b writes %0d, want 0 0 0", bus.done, bus.busy, n_wr - w0);
    end
  endtask

  task automatic test_stall_abort();
    int w0, d0;
    w0 = n_wr; d0 = n_done;
    bus.op_ready = 1'b0;
    alu_en = 1'b0;
    launch(5'd9, 5'd11, 5'd3, 7'd1, 3'b000, 3'b000);
    // neighbouring bytes 0x13,0x12,0x11 must not leak into op_a
    for (int c = 0; c < 5; c++) begin
      vec++;
      if (bus.op_valid !== 1'b1 || bus.op_a !== 32'h10 || bus.op_b !== 32'hf0) begin
        errs++;
        $display("FAIL stall_hold[%0d]: op_valid %b op_a %h op_b %h, want 1 00000010 000000f0",
                 c, bus.op_valid, bus.op_a, bus.op_b);
      end
      tick();
    end
    bus.op_ready = 1'b1;
    tick();
    vec++;
    if (bus.op_valid !== 1'b0 || bus.busy !== 1'b1) begin
      errs++;
      $display("FAIL stall_to_wait: op_valid %b busy %b, want 0 1", bus.op_valid, bus.busy);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    vec++;
    if (bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL abort_idle: busy %b, want 0", bus.busy);
    end
    alu_en = 1'b1;
    repeat (3) tick();
    vec++;
    if (n_wr !== w0 || n_done !== d0) begin
      errs++;
      $display("FAIL abort_quiet: %0d writes %0d done, want 0 0", n_wr - w0, n_done - d0);
    end
  endtask

  task automatic test_reset_mid();
    int w0, d0;
    bit hit;
    hit = 1'b0;
    load_basic();
    w0 = n_wr; d0 = n_done;
    launch(5'd2, 5'd3, 5'd5, 7'd4, 3'b010, 3'b000);
    for (int c = 0; c < 30 && !hit; c++) begin
      if (bus.el_wr_en && bus.el_wr_addr == 5'd2) hit = 1'b1;
      else tick();
    end
    vec++;
    if (!hit) begin
      errs++;
      $display("FAIL rst_mid_reach: write of element 2 not seen, want seen");
    end
    #2 nrst = 1'b0;
    #1;
    vec++;
    if (bus.el_wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.el_reg_wr_addr !== 5'd0) begin
      errs++;
      $display("FAIL rst_mid_now: wr_en %b busy %b wreg %0d, want 0 0 0",
               bus.el_wr_en, bus.busy, bus.el_reg_wr_addr);
    end
    repeat (2) tick();
    nrst = 1'b1;
    repeat (5) tick();
    vec++;
    if (bus.busy !== 1'b0 || n_wr - w0 !== 2 || n_done !== d0) begin
      errs++;
      $display("FAIL rst_mid_after: busy %b writes %0d done %0d, want 0 2 0",
               bus.busy, n_wr - w0, n_done - d0);
    end
  endtask

  task automatic test_start_busy();
    int w0, d0;
    bit ok;
    load_basic();
    w0 = n_wr; d0 = n_done;
    launch(5'd2, 5'd3, 5'd5, 7'd4, 3'b010, 3'b000);
    tick();
    bus.vs1 = 5'd8; bus.vs2 = 5'd10; bus.vd = 5'd9; bus.vl = 7'd1; bus.sew = 3'b000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_idle("start_busy", 40);
    ok = (n_wr - w0 == 4) && (n_done - d0 == 1);
    for (int i = 0; i < 4 && ok; i++)
      if (wr_reg[w0+i] !== 5'd5 || wr_lane[w0+i] !== 5'(i)) ok = 1'b0;
    vec++;
    if (!ok) begin
      errs++;
      $display("FAIL start_busy_ignored: %0d writes %0d done (first reg %0d), want 4 writes to reg 5, 1 done",
               n_wr - w0, n_done - d0, wr_reg[w0]);
    end
    vec++;
    if (wr_dat[w0+3] !== {32'h2c, 96'd0}) begin
      errs++;
      $display("FAIL start_busy_data: last data %h, want 2c<<96", wr_dat[w0+3]);
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = '0;
    test_reset();
    test_basic();
    test_group();
    test_large();
    test_wrap();
    test_zero_vl();
    test_stall_abort();
    test_reset_mid();
    test_start_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/v_elem_sequencer.md
V_ELEM_SEQUENCER -- requirements
Module: v_elem_sequencer

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 nrst  in  1  asynchronous active-low reset.
REQ-004 start, abort  in  1 each  start: launch operation (pulse); abort: cancel operation.
REQ-005 vs1, vs2, vd  in  5 each  base register numbers of source and destination groups.
REQ-006 vl  in  7  element count 0..64; sew  in  3  element width code; lmul  in  3  group size code.
REQ-007 el_rd_addr_1, el_rd_addr_2, el_addr_1, el_addr_2  out  5 each  regfile element read selects.
REQ-008 el_data_in_1, el_data_in_2  in  32 each  regfile element read data, combinational from the selects.
REQ-009 el_wr_en  out  1; el_reg_wr_addr, el_wr_addr  out  5 each; el_wr_data  out  128  regfile element write port.
REQ-010 op_valid  out  1; op_ready  in  1; op_a, op_b  out  32 each  operand handshake to the element ALU.
REQ-011 res_valid  in  1; res_data  in  32  result from the element ALU.
REQ-012 busy, done  out  1 each  busy: operation in progress; done: one-cycle completion pulse.

Function
REQ-013 Elements per register (epr) SHALL be: sew 000 = 16, sew 001 = 8, sew 010 = 4, any other sew = 16 with 8-bit elements.
REQ-014 Registers per group (rpg) SHALL be: lmul 000 = 1, lmul 001 = 2, lmul 010 = 4, any other lmul = 1.
REQ-015 Effective count SHALL be min(vl, epr*rpg), computed and latched at start together with vs1, vs2, vd, sew and lmul.
REQ-016 States SHALL be IDLE, ISSUE, WAIT, WRITE and DONE; busy=1 in every state except IDLE.
REQ-017 IDLE: start with count>0 -> ISSUE with idx=0; start with count=0 -> DONE.
REQ-018 start SHALL be ignored when the block is not in IDLE.
REQ-019 For element idx: reg offset = idx / epr and lane = idx mod epr.
REQ-020 Register addresses SHALL be base + offset, modulo 32; el_addr_1 = el_addr_2 = el_wr_addr = lane.
REQ-021 ISSUE: op_valid=1; op_a and op_b SHALL carry el_data_in_1 and el_data_in_2 zero-extended from SEW bits.
REQ-022 op_valid, op_a and op_b SHALL stay stable until op_ready=1, after which the block moves to WAIT.
REQ-023 WAIT: on res_valid=1 the block SHALL register res_data (truncated to SEW) and move to WRITE; res_valid in any other state SHALL be ignored.
REQ-024 WRITE: el_wr_en=1 for exactly one cycle, el_reg_wr_addr = vd + offset.
REQ-025 In WRITE, el_wr_data SHALL hold the result at bits [lane*SEW +: SEW] and zero in all other bits.
REQ-026 After WRITE: if idx = count-1 -> DONE, else idx+1 -> ISSUE.
REQ-027 DONE: done=1 for one cycle -> IDLE.
REQ-028 abort in any non-IDLE state SHALL move the block to IDLE on the next edge with no write and no done pulse, and SHALL override a same-cycle WRITE-to-next transition.
REQ-029 Minimum latency per element SHALL be 3 cycles (ISSUE, WAIT, WRITE) when op_ready and res_valid are both 1 on first opportunity.

Reset
REQ-030 While nrst=0, the block SHALL be in IDLE with idx=0 and all latched configuration cleared.
REQ-031 While nrst=0, busy, done, op_valid and el_wr_en SHALL be 0, and every address/data output SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL abandon the operation immediately, with no further writes after release.

Verification
REQ-033 sew=010, lmul=000, vl=4, vs1=2, vs2=3, vd=5, ALU adds with 1-cycle latency -> four writes to reg 5 at lanes 0..3, el_wr_data lane bits = sum, done after 12 busy cycles, busy for 13 cycles.
REQ-034 sew=000, lmul=001, vl=20, vd=30 -> elements 0..15 written to reg 30 and elements 16..19 to reg 31 at lanes 0..3.
REQ-035 Two further cases: vl=40 with sew=001, lmul=010 -> count 32; vd=31, lmul=001 -> second register wraps to reg 0.
REQ-036 vl=0 start -> done one cycle after start, el_wr_en never asserted.
REQ-037 op_ready held 0 for 5 cycles -> op_valid/op_a/op_b stable all 5 cycles; then abort in WAIT -> IDLE, no write, no done.
REQ-038 nrst low during WRITE of element 2 -> el_wr_en=0 immediately, IDLE after release; start while busy -> ignored.
